// File: rtl/frame_mem_arbiter.sv
// Two-master round-robin arbiter for the single-port frame memory, with read-return routing and an out-of-range guard.
// Define MEMARB_FIXED_PRIO_EN to replace round-robin with fixed m0 priority.
module frame_mem_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 76800,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  oor_error
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    in_range = (64'(addr) < 64'(DEPTH));
  endfunction

  logic              req0_s, req1_s, gnt0_s, gnt1_s, any_gnt_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_read_s, sel_write_s, sel_in_range_s;
  logic [DATA_W-1:0] ret_data_s;

  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_id_q, ret_id_d;
  logic              ret_oor_q, ret_oor_d;
  logic [DATA_W-1:0] rd_hold0_q, rd_hold0_d;
  logic [DATA_W-1:0] rd_hold1_q, rd_hold1_d;
  logic              oor_q, oor_d;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  // Grant decision; nothing is granted while reset is high.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
    end else if (req0_s && !req1_s) begin
      gnt0_s = 1'b1;
    end else if (!req0_s && req1_s) begin
      gnt1_s = 1'b1;
    end else if (req0_s && req1_s) begin
`ifdef MEMARB_FIXED_PRIO_EN
      gnt0_s = 1'b1;
`else
      if (cnt_q == {CNT_W{1'b0}}) begin
        gnt0_s = 1'b1;
      end else if (cnt_q < MAX_CNT) begin
        gnt0_s = !owner_q;
        gnt1_s = owner_q;
      end else begin
        gnt0_s = owner_q;
        gnt1_s = !owner_q;
      end
`endif
    end else begin
      gnt0_s = 1'b0;
    end
  end

  assign any_gnt_s = gnt0_s | gnt1_s;

  // Steer the granted master onto the memory port; read is ignored when write is also high.
  always_comb begin
    sel_addr_s     = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    sel_read_s     = m0_read & ~m0_write;
    sel_write_s    = m0_write;
    if (gnt1_s) begin
      sel_addr_s     = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      sel_read_s     = m1_read & ~m1_write;
      sel_write_s    = m1_write;
    end else begin
      sel_addr_s     = m0_address;
    end
  end

  assign sel_in_range_s = in_range(sel_addr_s);
  assign mem_address    = sel_addr_s;
  assign mem_chipselect = any_gnt_s & sel_in_range_s;
  assign mem_write      = mem_chipselect & sel_write_s;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = reset | (req0_s & ~gnt0_s);
  assign m1_waitrequest = reset | (req1_s & ~gnt1_s);

  // Burst tracking: cnt saturates at MAX_CNT when a lone requester streams.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!any_gnt_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((cnt_q != {CNT_W{1'b0}}) && (gnt1_s == owner_q)) begin
      if (cnt_q < MAX_CNT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      owner_d = gnt1_s;
      cnt_d   = CNT_W'(1);
    end
  end

  // Return register, per-master readdata hold and sticky out-of-range flag.
  always_comb begin
    ret_valid_d = any_gnt_s & sel_read_s;
    ret_id_d    = gnt1_s;
    ret_oor_d   = ~sel_in_range_s;
    oor_d       = oor_q | (any_gnt_s & ~sel_in_range_s);
    ret_data_s  = ret_oor_q ? {DATA_W{1'b0}} : mem_readdata;
    rd_hold0_d  = rd_hold0_q;
    rd_hold1_d  = rd_hold1_q;
    if (ret_valid_q && !ret_id_q) begin
      rd_hold0_d = ret_data_s;
    end else if (ret_valid_q && ret_id_q) begin
      rd_hold1_d = ret_data_s;
    end else begin
      rd_hold0_d = rd_hold0_q;
    end
  end

  // Read-return outputs; gating with reset kills a return that was pending when reset rose.
  always_comb begin
    m0_readdatavalid = ~reset & ret_valid_q & ~ret_id_q;
    m1_readdatavalid = ~reset & ret_valid_q & ret_id_q;
    oor_error        = ~reset & oor_q;
    m0_readdata      = rd_hold0_q;
    m1_readdata      = rd_hold1_q;
    if (reset) begin
      m0_readdata = {DATA_W{1'b0}};
      m1_readdata = {DATA_W{1'b0}};
    end else if (m0_readdatavalid) begin
      m0_readdata = ret_data_s;
    end else if (m1_readdatavalid) begin
      m1_readdata = ret_data_s;
    end else begin
      m0_readdata = rd_hold0_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= 1'b1;
      cnt_q       <= {CNT_W{1'b0}};
      ret_valid_q <= 1'b0;
      ret_id_q    <= 1'b0;
      ret_oor_q   <= 1'b0;
      rd_hold0_q  <= {DATA_W{1'b0}};
      rd_hold1_q  <= {DATA_W{1'b0}};
      oor_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_id_q    <= ret_id_d;
      ret_oor_q   <= ret_oor_d;
      rd_hold0_q  <= rd_hold0_d;
      rd_hold1_q  <= rd_hold1_d;
      oor_q       <= oor_d;
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter with a behavioural one-cycle-latency frame memory.
module tb_frame_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken, oor_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_model [0:76799];
  logic [16:0] mem_raddr_q = 17'd0;

  always #5 clk = ~clk;

  frame_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .oor_error(oor_error)
  );

  // Frame memory: registered address, unregistered read data, byte-lane writes.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_raddr_q <= mem_address;
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end
  assign mem_readdata = mem_model[mem_raddr_q];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [16:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [16:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 17'd0, 32'd0, 4'd0);
    drive1(1'b0, 1'b0, 17'd0, 32'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  int g, prev_g;

  initial begin
    reset = 1'b1;
    idle();
    drive0(1'b0, 1'b1, 17'd3, 32'h0000_0001, 4'hF);
    drive1(1'b1, 1'b0, 17'd4, 32'd0, 4'd0);
    sample();
    check_val("rst_wait0", {31'd0, m0_waitrequest}, 32'd1);
    check_val("rst_wait1", {31'd0, m1_waitrequest}, 32'd1);
    check_val("rst_cs", {31'd0, mem_chipselect}, 32'd0);
    check_val("rst_mwr", {31'd0, mem_write}, 32'd0);
    check_val("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    check_val("rst_rdata0", m0_readdata, 32'd0);
    check_val("rst_oor", {31'd0, oor_error}, 32'd0);
    tick();
    reset = 1'b0;
    idle();

    // m0 full write to addr 5, then m1 reads it back.
    drive0(1'b0, 1'b1, 17'd5, 32'hDEADBEEF, 4'hF);
    sample();
    check_val("wr5_wait0", {31'd0, m0_waitrequest}, 32'd0);
    check_val("wr5_cs_wr", {30'd0, mem_chipselect, mem_write}, 32'd3);
    check_val("wr5_addr", {15'd0, mem_address}, 32'd5);
    tick();
    idle();
    drive1(1'b1, 1'b0, 17'd5, 32'd0, 4'd0);
    sample();
    check_val("rd5_wait1", {31'd0, m1_waitrequest}, 32'd0);
    check_val("rd5_cs_wr", {30'd0, mem_chipselect, mem_write}, 32'd2);
    tick();
    idle();
    sample();
    check_val("rd5_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd2);
    check_val("rd5_data", m1_readdata, 32'hDEADBEEF);
    tick();

    // Partial write over all-ones at addr 10, read back by m0.
    drive0(1'b0, 1'b1, 17'd10, 32'hFFFFFFFF, 4'hF);
    tick();
    drive0(1'b0, 1'b1, 17'd10, 32'h11223344, 4'b0101);
    tick();
    drive0(1'b1, 1'b0, 17'd10, 32'd0, 4'd0);
    tick();
    idle();
    sample();
    check_val("pw_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd1);
    check_val("pw_data", m0_readdata, 32'hFF22FF44);
    check_val("pw_m1_hold", m1_readdata, 32'hDEADBEEF);
    tick();

    // read+write together is a write with no read return.
    drive1(1'b1, 1'b1, 17'd20, 32'h12345678, 4'hF);
    sample();
    check_val("rw_mwr", {31'd0, mem_write}, 32'd1);
    tick();
    drive1(1'b1, 1'b0, 17'd20, 32'd0, 4'd0);
    sample();
    check_val("rw_no_rdv", {31'd0, m1_readdatavalid}, 32'd0);
    tick();
    idle();
    sample();
    check_val("rw_data", m1_readdata, 32'h12345678);
    tick();

    // Continuous contention: m0 reads addr 10, m1 reads addr 5.
    prev_g = -1;
    drive0(1'b1, 1'b0, 17'd10, 32'd0, 4'd0);
    drive1(1'b1, 1'b0, 17'd5, 32'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
`ifdef MEMARB_FIXED_PRIO_EN
      g = 0;
`else
      g = (i / 4) % 2;
`endif
      sample();
      check_val($sformatf("rr%0d_wait0", i), {31'd0, m0_waitrequest}, (g != 0) ? 32'd1 : 32'd0);
      check_val($sformatf("rr%0d_wait1", i), {31'd0, m1_waitrequest}, (g != 1) ? 32'd1 : 32'd0);
      check_val($sformatf("rr%0d_addr", i), {15'd0, mem_address}, (g == 1) ? 32'd5 : 32'd10);
      if (prev_g >= 0) begin
        check_val($sformatf("rr%0d_rdv", i), {30'd0, m1_readdatavalid, m0_readdatavalid},
                  (prev_g == 1) ? 32'd2 : 32'd1);
      end
      prev_g = g;
      tick();
    end
    idle();
    sample();
    check_val("rr_last_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid},
              (prev_g == 1) ? 32'd2 : 32'd1);
    check_val("rr_last_data", (prev_g == 1) ? m1_readdata : m0_readdata,
              (prev_g == 1) ? 32'hDEADBEEF : 32'hFF22FF44);
    tick();

    // Out-of-range boundary: DEPTH-1 in range, DEPTH not.
    drive0(1'b0, 1'b1, 17'd76799, 32'hCAFEF00D, 4'hF);
    sample();
    check_val("edge_wr_cs", {31'd0, mem_chipselect}, 32'd1);
    check_val("pre_oor", {31'd0, oor_error}, 32'd0);
    tick();
    drive0(1'b0, 1'b1, 17'd76800, 32'h55555555, 4'hF);
    sample();
    check_val("oor_wr_cs_wr", {30'd0, mem_chipselect, mem_write}, 32'd0);
    check_val("oor_wr_wait", {31'd0, m0_waitrequest}, 32'd0);
    tick();
    idle();
    drive1(1'b1, 1'b0, 17'd76800, 32'd0, 4'd0);
    sample();
    check_val("oor_rd_wait", {31'd0, m1_waitrequest}, 32'd0);
    check_val("oor_rd_cs", {31'd0, mem_chipselect}, 32'd0);
    tick();
    drive1(1'b1, 1'b0, 17'd76799, 32'd0, 4'd0);
    sample();
    check_val("oor_rd_rdv", {31'd0, m1_readdatavalid}, 32'd1);
    check_val("oor_rd_data", m1_readdata, 32'd0);
    check_val("oor_flag", {31'd0, oor_error}, 32'd1);
    tick();
    idle();
    sample();
    check_val("edge_rd_data", m1_readdata, 32'hCAFEF00D);
    check_val("oor_sticky", {31'd0, oor_error}, 32'd1);
    tick();

    // Reset asserted the cycle after an accepted read.
    drive1(1'b1, 1'b0, 17'd5, 32'd0, 4'd0);
    sample();
    check_val("mr_wait1", {31'd0, m1_waitrequest}, 32'd0);
    tick();
    reset = 1'b1;
    idle();
    sample();
    check_val("mr_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    check_val("mr_rdata", m1_readdata | m0_readdata, 32'd0);
    check_val("mr_oor", {31'd0, oor_error}, 32'd0);
    check_val("mr_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    tick();
    reset = 1'b0;
    sample();
    check_val("post_rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    check_val("post_rst_oor", {31'd0, oor_error}, 32'd0);
    check_val("post_rst_rdata", m0_readdata | m1_readdata, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
